// File: rtl/prepare_log_ctrl_multi.sv
// Prepare-path log writer control: ingest pass-through plus all-or-nothing circular log entry writes.
// Optional build macro PREP_LOG_BEAT_CHECK_EN adds a sticky beat-count error output (o_log_beat_err).
module prepare_log_ctrl_multi #(
  parameter int LOG_ADDR_W = 8,
  parameter int BEAT_W     = 6,
  parameter int CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start_req_ingest,
  input  logic [BEAT_W-1:0]     i_start_req_beats,
  output logic                  o_start_req_rdy,
  output logic                  o_log_write_done,
  input  logic                  i_manage_prep_req_val,
  input  logic                  i_manage_prep_req_last,
  output logic                  o_prep_manage_req_rdy,
  output logic                  o_log_ctrl_realign_wr_val,
  output logic                  o_log_ctrl_realign_wr_last,
  input  logic                  i_realign_log_ctrl_wr_rdy,
  input  logic                  i_insert_log_ctrl_rd_val,
  input  logic                  i_insert_log_ctrl_rd_last,
  output logic                  o_log_ctrl_insert_rd_rdy,
  output logic                  o_prep_log_mem_wr_val,
  output logic [LOG_ADDR_W-1:0] o_prep_log_mem_wr_addr,
  input  logic                  i_log_mem_prep_wr_rdy,
  input  logic                  i_log_mem_free_val,
  input  logic [LOG_ADDR_W:0]   i_log_mem_free_beats,
  output logic [LOG_ADDR_W:0]   o_log_used,
  output logic [CNT_W-1:0]      o_log_entry_cnt,
  output logic [CNT_W-1:0]      o_log_drop_cnt
`ifdef PREP_LOG_BEAT_CHECK_EN
  ,
  output logic                  o_log_beat_err
`endif
);

  localparam int DEPTH = 2**LOG_ADDR_W;
  localparam int CMP_W = ((BEAT_W > LOG_ADDR_W + 1) ? BEAT_W : LOG_ADDR_W + 1) + 1;
  localparam int UW    = LOG_ADDR_W + 2;

  // ingest: WAITING | INGESTING ; log: READY | WRITING | DRAINING (entry consumed, not stored)
  localparam logic [0:0] ING_WAITING   = 1'b0;
  localparam logic [0:0] ING_INGESTING = 1'b1;
  localparam logic [1:0] LOG_READY     = 2'd0;
  localparam logic [1:0] LOG_WRITING   = 2'd1;
  localparam logic [1:0] LOG_DRAINING  = 2'd2;

  logic [0:0]            r_ing_state;
  logic [1:0]            r_log_state;
  logic [LOG_ADDR_W-1:0] r_head;
  logic [LOG_ADDR_W:0]   r_used;
  logic [CNT_W-1:0]      r_entry_cnt;
  logic [CNT_W-1:0]      r_drop_cnt;

  logic                  w_start_fire;
  logic                  w_fits;
  logic                  w_excess;
  logic                  w_ins_fire;
  logic                  w_ins_last_fire;
  logic                  w_wr_fire;
  logic [CMP_W-1:0]      w_space;
  logic [CMP_W-1:0]      w_req_ext;
  logic [UW-1:0]         w_used_inc;
  logic [UW-1:0]         w_free_req;
  logic [UW-1:0]         w_free_amt;
  logic [LOG_ADDR_W:0]   w_used_next;

  assign o_start_req_rdy  = (r_ing_state == ING_WAITING) && (r_log_state == LOG_READY);
  assign o_log_write_done = (r_log_state == LOG_READY);
  assign w_start_fire     = i_start_req_ingest & o_start_req_rdy;

  assign o_log_ctrl_realign_wr_val  = (r_ing_state == ING_INGESTING) & i_manage_prep_req_val;
  assign o_log_ctrl_realign_wr_last = (r_ing_state == ING_INGESTING) & i_manage_prep_req_last;
  assign o_prep_manage_req_rdy      = (r_ing_state == ING_INGESTING) & i_realign_log_ctrl_wr_rdy;

  // Only one entry is ever in flight, so the current occupancy is the whole reservation picture.
  assign w_space   = CMP_W'(DEPTH) - CMP_W'(r_used);
  assign w_req_ext = CMP_W'(i_start_req_beats);
  assign w_fits    = (i_start_req_beats != '0) && (w_req_ext <= w_space);

`ifdef PREP_LOG_BEAT_CHECK_EN
  logic [BEAT_W-1:0] r_req_beats;
  logic [BEAT_W-1:0] r_beat_cnt;
  logic              r_beat_err;

  assign w_excess       = (r_beat_cnt >= r_req_beats);
  assign o_log_beat_err = r_beat_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_req_beats <= '0;
      r_beat_cnt  <= '0;
      r_beat_err  <= 1'b0;
    end else if (w_start_fire) begin
      r_req_beats <= i_start_req_beats;
      r_beat_cnt  <= '0;
    end else if (w_ins_fire) begin
      if (!w_excess)
        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
      if (w_excess || (i_insert_log_ctrl_rd_last &&
          (({1'b0, r_beat_cnt} + (BEAT_W+1)'(1)) != {1'b0, r_req_beats})))
        r_beat_err <= 1'b1;
    end
  end
`else
  assign w_excess = 1'b0;
`endif

  always_comb begin
    o_prep_log_mem_wr_val    = 1'b0;
    o_log_ctrl_insert_rd_rdy = 1'b0;
    case (r_log_state)
      LOG_WRITING: begin
        o_prep_log_mem_wr_val    = i_insert_log_ctrl_rd_val & ~w_excess;
        o_log_ctrl_insert_rd_rdy = w_excess | i_log_mem_prep_wr_rdy;
      end
      LOG_DRAINING: o_log_ctrl_insert_rd_rdy = 1'b1;
      default: ;
    endcase
  end

  assign w_ins_fire      = i_insert_log_ctrl_rd_val & o_log_ctrl_insert_rd_rdy;
  assign w_ins_last_fire = w_ins_fire & i_insert_log_ctrl_rd_last;
  assign w_wr_fire       = o_prep_log_mem_wr_val & i_log_mem_prep_wr_rdy;

  assign w_used_inc  = UW'(r_used) + UW'(w_wr_fire);
  assign w_free_req  = UW'(i_log_mem_free_beats);
  assign w_free_amt  = !i_log_mem_free_val ? '0 :
                       ((w_free_req < w_used_inc) ? w_free_req : w_used_inc);
  assign w_used_next = (LOG_ADDR_W+1)'(w_used_inc - w_free_amt);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ing_state <= ING_WAITING;
    end else begin
      case (r_ing_state)
        ING_WAITING:
          if (w_start_fire) r_ing_state <= ING_INGESTING;
        default:
          if (o_log_ctrl_realign_wr_val && i_realign_log_ctrl_wr_rdy && o_log_ctrl_realign_wr_last)
            r_ing_state <= ING_WAITING;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_log_state <= LOG_READY;
      r_entry_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      case (r_log_state)
        LOG_READY:
          if (w_start_fire) r_log_state <= w_fits ? LOG_WRITING : LOG_DRAINING;
        LOG_WRITING:
          if (w_ins_last_fire) begin
            r_entry_cnt <= r_entry_cnt + CNT_W'(1);
            r_log_state <= LOG_READY;
          end
        LOG_DRAINING:
          if (w_ins_last_fire) begin
            r_drop_cnt  <= r_drop_cnt + CNT_W'(1);
            r_log_state <= LOG_READY;
          end
        default: r_log_state <= LOG_READY;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_head <= '0;
      r_used <= '0;
    end else begin
      if (w_wr_fire) r_head <= r_head + LOG_ADDR_W'(1);
      r_used <= w_used_next;
    end
  end

  assign o_prep_log_mem_wr_addr = r_head;
  assign o_log_used             = r_used;
  assign o_log_entry_cnt        = r_entry_cnt;
  assign o_log_drop_cnt         = r_drop_cnt;

endmodule

// File: tb/tb_prepare_log_ctrl_multi.sv
// Directed bench for prepare_log_ctrl_multi built with an 8-beat log (LOG_ADDR_W=3).
module tb_prepare_log_ctrl_multi;

  localparam int LAW = 3;
  localparam int BW  = 4;
  localparam int CW  = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start_val = 1'b0;
  logic [BW-1:0]  start_beats = '0;
  logic           start_rdy, done;
  logic           man_val = 1'b0, man_last = 1'b0, man_rdy;
  logic           rl_val, rl_last;
  logic           rl_rdy = 1'b1;
  logic           ins_val = 1'b0, ins_last = 1'b0, ins_rdy;
  logic           mem_val;
  logic [LAW-1:0] mem_addr;
  logic           mem_rdy = 1'b1;
  logic           free_val = 1'b0;
  logic [LAW:0]   free_beats = '0;
  logic [LAW:0]   used;
  logic [CW-1:0]  entry_cnt, drop_cnt;
`ifdef PREP_LOG_BEAT_CHECK_EN
  logic           beat_err;
`endif

  int pass_cnt = 0;
  int tot_cnt  = 0;
  int wr_q[$];
  int ins_fires = 0;
  int rl_fires  = 0;
  int rl_lasts  = 0;

  always #5 clk = ~clk;

  prepare_log_ctrl_multi #(.LOG_ADDR_W(LAW), .BEAT_W(BW), .CNT_W(CW)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_start_req_ingest(start_val), .i_start_req_beats(start_beats),
    .o_start_req_rdy(start_rdy), .o_log_write_done(done),
    .i_manage_prep_req_val(man_val), .i_manage_prep_req_last(man_last),
    .o_prep_manage_req_rdy(man_rdy),
    .o_log_ctrl_realign_wr_val(rl_val), .o_log_ctrl_realign_wr_last(rl_last),
    .i_realign_log_ctrl_wr_rdy(rl_rdy),
    .i_insert_log_ctrl_rd_val(ins_val), .i_insert_log_ctrl_rd_last(ins_last),
    .o_log_ctrl_insert_rd_rdy(ins_rdy),
    .o_prep_log_mem_wr_val(mem_val), .o_prep_log_mem_wr_addr(mem_addr),
    .i_log_mem_prep_wr_rdy(mem_rdy),
    .i_log_mem_free_val(free_val), .i_log_mem_free_beats(free_beats),
    .o_log_used(used), .o_log_entry_cnt(entry_cnt), .o_log_drop_cnt(drop_cnt)
`ifdef PREP_LOG_BEAT_CHECK_EN
    , .o_log_beat_err(beat_err)
`endif
  );

  always @(posedge clk) begin
    if (!rst) begin
      if (mem_val && mem_rdy) wr_q.push_back(int'(mem_addr));
      if (ins_val && ins_rdy) ins_fires++;
      if (rl_val && rl_rdy) begin
        rl_fires++;
        if (rl_last) rl_lasts++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic send_start(input int b, output bit acc);
    @(negedge clk);
    start_val = 1'b1; start_beats = BW'(b);
    #1 acc = start_rdy;
    @(negedge clk);
    start_val = 1'b0;
  endtask

  task automatic drive_ingest(input int n, input bit tog, output bit ok);
    int sent; int cyc; bit ph;
    sent = 0; cyc = 0; ph = 1'b0;
    while (sent < n && cyc < 100) begin
      @(negedge clk);
      man_val = 1'b1; man_last = (sent == n - 1);
      rl_rdy = tog ? ph : 1'b1; ph = ~ph;
      #1 if (man_rdy) sent++;
      cyc++;
    end
    @(negedge clk);
    man_val = 1'b0; man_last = 1'b0; rl_rdy = 1'b1;
    ok = (sent == n);
  endtask

  task automatic drive_insert(input int n, input bit tog, output bit ok);
    int sent; int cyc; bit ph;
    sent = 0; cyc = 0; ph = 1'b0;
    while (sent < n && cyc < 100) begin
      @(negedge clk);
      ins_val = 1'b1; ins_last = (sent == n - 1);
      mem_rdy = tog ? ph : 1'b1; ph = ~ph;
      #1 if (ins_rdy) sent++;
      cyc++;
    end
    @(negedge clk);
    ins_val = 1'b0; ins_last = 1'b0; mem_rdy = 1'b1;
    ok = (sent == n);
  endtask

  task automatic do_free(input int k);
    @(negedge clk);
    free_val = 1'b1; free_beats = (LAW+1)'(k);
    @(negedge clk);
    free_val = 1'b0; free_beats = '0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    tot_cnt++; if (start_rdy !== 1'b1) $display("FAIL rst_start_rdy: got %b want 1", start_rdy); else pass_cnt++;
    tot_cnt++; if (done !== 1'b1) $display("FAIL rst_done: got %b want 1", done); else pass_cnt++;
    tot_cnt++; if (used !== '0) $display("FAIL rst_used: got %0d want 0", used); else pass_cnt++;
    tot_cnt++; if ({mem_val, ins_rdy, man_rdy, rl_val} !== 4'b0) $display("FAIL rst_valrdy: got %b want 0000", {mem_val, ins_rdy, man_rdy, rl_val}); else pass_cnt++;
    tot_cnt++; if ({entry_cnt, drop_cnt} !== '0) $display("FAIL rst_cnts: got %0d/%0d want 0/0", entry_cnt, drop_cnt); else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_basic_write;
    int e[4] = '{0, 1, 2, 3};
    bit acc, ok1, ok2;
    wr_q.delete();
    send_start(4, acc);
    tot_cnt++; if (acc !== 1'b1) $display("FAIL basic_accept: got %b want 1", acc); else pass_cnt++;
    tot_cnt++; if (done !== 1'b0) $display("FAIL basic_busy: got done=%b want 0", done); else pass_cnt++;
    drive_ingest(2, 1'b0, ok1);
    drive_insert(4, 1'b0, ok2);
    tot_cnt++; if ({ok1, ok2} !== 2'b11) $display("FAIL basic_timeout: got %b want 11", {ok1, ok2}); else pass_cnt++;
    tot_cnt++; if (wr_q.size() !== 4) $display("FAIL basic_nwr: got %0d want 4", wr_q.size()); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tot_cnt++; if (wr_q.size() <= i || wr_q[i] !== e[i]) $display("FAIL basic_addr%0d: got %0d want %0d", i, (wr_q.size() > i) ? wr_q[i] : -1, e[i]); else pass_cnt++;
    end
    tot_cnt++; if (used !== 4'd4) $display("FAIL basic_used: got %0d want 4", used); else pass_cnt++;
    tot_cnt++; if (entry_cnt !== 8'd1) $display("FAIL basic_entry: got %0d want 1", entry_cnt); else pass_cnt++;
    tot_cnt++; if (done !== 1'b1) $display("FAIL basic_done: got %b want 1", done); else pass_cnt++;
    do_free(4);
    tot_cnt++; if (used !== 4'd0) $display("FAIL basic_free: got %0d want 0", used); else pass_cnt++;
  endtask

  task automatic test_drain;
    int e[6] = '{4, 5, 6, 7, 0, 1};
    bit acc, ok1, ok2;
    wr_q.delete();
    send_start(6, acc); drive_ingest(1, 1'b0, ok1); drive_insert(6, 1'b0, ok2);
    tot_cnt++; if (wr_q.size() !== 6) $display("FAIL fill_nwr: got %0d want 6", wr_q.size()); else pass_cnt++;
    for (int i = 0; i < 6; i++) begin
      tot_cnt++; if (wr_q.size() <= i || wr_q[i] !== e[i]) $display("FAIL fill_addr%0d: got %0d want %0d", i, (wr_q.size() > i) ? wr_q[i] : -1, e[i]); else pass_cnt++;
    end
    tot_cnt++; if (used !== 4'd6) $display("FAIL fill_used: got %0d want 6", used); else pass_cnt++;
    wr_q.delete(); ins_fires = 0;
    send_start(3, acc);
    tot_cnt++; if (acc !== 1'b1) $display("FAIL drain_accept: got %b want 1", acc); else pass_cnt++;
    drive_ingest(1, 1'b0, ok1); drive_insert(3, 1'b0, ok2);
    tot_cnt++; if ({ok1, ok2} !== 2'b11) $display("FAIL drain_timeout: got %b want 11", {ok1, ok2}); else pass_cnt++;
    tot_cnt++; if (wr_q.size() !== 0) $display("FAIL drain_nwr: got %0d want 0", wr_q.size()); else pass_cnt++;
    tot_cnt++; if (ins_fires !== 3) $display("FAIL drain_consumed: got %0d want 3", ins_fires); else pass_cnt++;
    tot_cnt++; if (drop_cnt !== 8'd1) $display("FAIL drain_drop: got %0d want 1", drop_cnt); else pass_cnt++;
    tot_cnt++; if (mem_addr !== 3'd2) $display("FAIL drain_addr: got %0d want 2", mem_addr); else pass_cnt++;
    tot_cnt++; if (used !== 4'd6) $display("FAIL drain_used: got %0d want 6", used); else pass_cnt++;
    send_start(0, acc); drive_ingest(1, 1'b0, ok1); drive_insert(1, 1'b0, ok2);
    tot_cnt++; if (drop_cnt !== 8'd2 || wr_q.size() !== 0) $display("FAIL zero_beats: got drop=%0d nwr=%0d want 2/0", drop_cnt, wr_q.size()); else pass_cnt++;
    send_start(2, acc); drive_ingest(1, 1'b0, ok1); drive_insert(2, 1'b0, ok2);
    tot_cnt++; if (wr_q.size() !== 2 || (wr_q.size() == 2 && (wr_q[0] !== 2 || wr_q[1] !== 3))) $display("FAIL exact_fit_wr: got n=%0d want 2,3", wr_q.size()); else pass_cnt++;
    tot_cnt++; if (used !== 4'd8) $display("FAIL exact_fit_used: got %0d want 8", used); else pass_cnt++;
    tot_cnt++; if (entry_cnt !== 8'd3) $display("FAIL exact_fit_entry: got %0d want 3", entry_cnt); else pass_cnt++;
  endtask

  task automatic test_wrap;
    int e[4] = '{6, 7, 0, 1};
    bit acc, ok1, ok2;
    do_free(8);
    tot_cnt++; if (used !== 4'd0) $display("FAIL wrap_free8: got %0d want 0", used); else pass_cnt++;
    send_start(2, acc); drive_ingest(1, 1'b0, ok1); drive_insert(2, 1'b0, ok2);
    tot_cnt++; if (used !== 4'd2 || mem_addr !== 3'd6) $display("FAIL wrap_prep: got used=%0d addr=%0d want 2/6", used, mem_addr); else pass_cnt++;
    do_free(9);
    tot_cnt++; if (used !== 4'd0) $display("FAIL overfree: got %0d want 0", used); else pass_cnt++;
    wr_q.delete();
    send_start(4, acc); drive_ingest(1, 1'b0, ok1); drive_insert(4, 1'b0, ok2);
    for (int i = 0; i < 4; i++) begin
      tot_cnt++; if (wr_q.size() <= i || wr_q[i] !== e[i]) $display("FAIL wrap_addr%0d: got %0d want %0d", i, (wr_q.size() > i) ? wr_q[i] : -1, e[i]); else pass_cnt++;
    end
    tot_cnt++; if (used !== 4'd4 || entry_cnt !== 8'd5) $display("FAIL wrap_state: got used=%0d entry=%0d want 4/5", used, entry_cnt); else pass_cnt++;
  endtask

  task automatic test_same_cycle;
    bit acc, ok1;
    wr_q.delete();
    send_start(2, acc); drive_ingest(1, 1'b0, ok1);
    @(negedge clk);
    ins_val = 1'b1; ins_last = 1'b0; mem_rdy = 1'b1;
    @(negedge clk);
    tot_cnt++; if (used !== 4'd5) $display("FAIL same_pre_used: got %0d want 5", used); else pass_cnt++;
    tot_cnt++; if (mem_addr !== 3'd3) $display("FAIL same_mid_addr: got %0d want 3", mem_addr); else pass_cnt++;
    ins_last = 1'b1; free_val = 1'b1; free_beats = 4'd1;
    @(negedge clk);
    ins_val = 1'b0; ins_last = 1'b0; free_val = 1'b0; free_beats = '0;
    tot_cnt++; if (used !== 4'd5) $display("FAIL same_cycle_used: got %0d want 5", used); else pass_cnt++;
    tot_cnt++; if (entry_cnt !== 8'd6 || done !== 1'b1) $display("FAIL same_cycle_end: got entry=%0d done=%b want 6/1", entry_cnt, done); else pass_cnt++;
    do_free(5);
  endtask

  task automatic test_back_to_back_stall;
    int e[5] = '{4, 5, 6, 7, 0};
    bit acc, ok1, ok2;
    wr_q.delete(); rl_fires = 0; rl_lasts = 0;
    send_start(5, acc);
    @(negedge clk);
    man_val = 1'b1; man_last = 1'b0; rl_rdy = 1'b0;
    #1;
    tot_cnt++; if (rl_val !== 1'b1 || man_rdy !== 1'b0) $display("FAIL stall_pass: got val=%b rdy=%b want 1/0", rl_val, man_rdy); else pass_cnt++;
    tot_cnt++; if (start_rdy !== 1'b0) $display("FAIL stall_rdy_ingest: got %b want 0", start_rdy); else pass_cnt++;
    man_val = 1'b0; rl_rdy = 1'b1;
    drive_ingest(3, 1'b1, ok1);
    tot_cnt++; if (start_rdy !== 1'b0) $display("FAIL stall_rdy_log: got %b want 0", start_rdy); else pass_cnt++;
    tot_cnt++; if (rl_fires !== 3 || rl_lasts !== 1) $display("FAIL stall_realign: got %0d/%0d want 3/1", rl_fires, rl_lasts); else pass_cnt++;
    drive_insert(5, 1'b1, ok2);
    tot_cnt++; if ({ok1, ok2} !== 2'b11) $display("FAIL stall_timeout: got %b want 11", {ok1, ok2}); else pass_cnt++;
    tot_cnt++; if (wr_q.size() !== 5) $display("FAIL stall_nwr: got %0d want 5", wr_q.size()); else pass_cnt++;
    for (int i = 0; i < 5; i++) begin
      tot_cnt++; if (wr_q.size() <= i || wr_q[i] !== e[i]) $display("FAIL stall_addr%0d: got %0d want %0d", i, (wr_q.size() > i) ? wr_q[i] : -1, e[i]); else pass_cnt++;
    end
    tot_cnt++; if (start_rdy !== 1'b1 || used !== 4'd5) $display("FAIL stall_end: got rdy=%b used=%0d want 1/5", start_rdy, used); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    int e[4] = '{0, 1, 2, 3};
    bit acc, ok1, ok2;
    do_free(5);
    wr_q.delete();
    send_start(4, acc); drive_ingest(1, 1'b0, ok1);
    @(negedge clk);
    ins_val = 1'b1; ins_last = 1'b0; mem_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    tot_cnt++; if (wr_q.size() !== 2 || used !== 4'd2) $display("FAIL midrst_pre: got n=%0d used=%0d want 2/2", wr_q.size(), used); else pass_cnt++;
    rst = 1'b1;
    #1;
    tot_cnt++; if ({mem_val, ins_rdy} !== 2'b00) $display("FAIL midrst_clear: got %b want 00", {mem_val, ins_rdy}); else pass_cnt++;
    tot_cnt++; if (mem_addr !== 3'd0 || used !== 4'd0) $display("FAIL midrst_ptr: got addr=%0d used=%0d want 0/0", mem_addr, used); else pass_cnt++;
    tot_cnt++; if ({start_rdy, done} !== 2'b11 || entry_cnt !== 8'd0) $display("FAIL midrst_idle: got %b entry=%0d want 11/0", {start_rdy, done}, entry_cnt); else pass_cnt++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    ins_val = 1'b0;
    tot_cnt++; if (wr_q.size() !== 2) $display("FAIL midrst_nowr: got %0d want 2", wr_q.size()); else pass_cnt++;
    wr_q.delete();
    send_start(4, acc); drive_ingest(1, 1'b0, ok1); drive_insert(4, 1'b0, ok2);
    for (int i = 0; i < 4; i++) begin
      tot_cnt++; if (wr_q.size() <= i || wr_q[i] !== e[i]) $display("FAIL fresh_addr%0d: got %0d want %0d", i, (wr_q.size() > i) ? wr_q[i] : -1, e[i]); else pass_cnt++;
    end
    tot_cnt++; if (used !== 4'd4 || entry_cnt !== 8'd1) $display("FAIL fresh_state: got used=%0d entry=%0d want 4/1", used, entry_cnt); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_write();
    test_drain();
    test_wrap();
    test_same_cycle();
    test_back_to_back_stall();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
